// File: rtl/muldiv_if.sv
// Bus between the CPU pipeline and the iterative multiply/divide unit.
// Handshake: start is sampled only while the unit is idle (busy=0, done=0); done is a
// one-cycle pulse with hi_out/lo_out valid, and those outputs hold until the next result or reset.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [1:0]       state_dbg;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, hi_out, lo_out, state_dbg
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, hi_out, lo_out, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply or restoring divide, one bit per
// cycle over 32 CALC cycles, then a FIX cycle for sign correction and result write.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic          launch, write_res, busy_next, done_next;
  logic          busy_q, done_q, div_zero_q;
  logic [W-1:0]  hi_q, lo_q;
  logic          is_div, b_zero, neg_res, neg_rem;
  logic [W-1:0]  a_raw, opnd;
  logic [2*W-1:0] acc;
  logic [CW-1:0] cnt;

  // Launch-time operand conditioning
  logic          sgn;
  logic [W-1:0]  mag_a_in, mag_b_in;
  assign sgn      = ~bus.op[0];
  assign mag_a_in = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
  assign mag_b_in = (sgn && bus.b[W-1]) ? -bus.b : bus.b;

  // One iteration of each algorithm; acc holds {hi, lo} for multiply and {rem, quo} for divide
  logic [W:0]     mul_sum;
  logic [W+1:0]   div_diff;
  logic [2*W-1:0] mul_next, div_next;
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc[W-1:1]};
  assign div_diff = {1'b0, acc[2*W-1:W-1]} - {2'b00, opnd};
  assign div_next = div_diff[W+1] ? {acc[2*W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    write_res  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          launch     = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.cancel)                  state_next = S_IDLE;
        else if (cnt == CW'(W - 1))      state_next = S_FIX;
      end
      S_FIX: begin
        if (bus.cancel) begin
          state_next = S_IDLE;
        end else begin
          write_res  = 1'b1;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // busy/done are registered from the next state so they carry no input-to-output path
    busy_next = (state_next == S_CALC) || (state_next == S_FIX);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_div     <= 1'b0;
      b_zero     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      a_raw      <= '0;
      opnd       <= '0;
      acc        <= '0;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      if (launch) begin
        is_div  <= bus.op[1];
        b_zero  <= (bus.b == '0);
        neg_res <= sgn && (bus.a[W-1] ^ bus.b[W-1]);
        neg_rem <= sgn && bus.a[W-1];
        a_raw   <= bus.a;
        opnd    <= bus.op[1] ? mag_b_in : mag_a_in;
        acc     <= {{W{1'b0}}, (bus.op[1] ? mag_a_in : mag_b_in)};
        cnt     <= '0;
      end else if (state == S_CALC) begin
        acc <= is_div ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end
      if (write_res) begin
        if (!is_div) begin
          hi_q       <= prod_fix[2*W-1:W];
          lo_q       <= prod_fix[W-1:0];
          div_zero_q <= 1'b0;
        end else if (b_zero) begin
          hi_q       <= a_raw;
          lo_q       <= '1;
          div_zero_q <= 1'b1;
        end else begin
          hi_q       <= rem_fix;
          lo_q       <= quo_fix;
          div_zero_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, cancel, ignored start, reset.
module tb_muldiv_unit;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;
  int   done_seen;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // returns ticks until done is seen, 0 on timeout
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int c;
    start_op(op, a, b);
    wait_done(c);
    check({tag, " latency"}, 64'(c), 64'd33);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi_out), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo_out), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    tick();
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, " back_idle"}, 64'(bus.state_dbg), 64'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);
    check("reset state", 64'(bus.state_dbg), 64'd0);
    rst = 1'b1;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_mixed", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("mult_negneg", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0);
    run_op("div_neg_a", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_neg_b", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1);

    // cancel on the 10th CALC cycle: outputs keep the divide-by-zero result
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel state", 64'(bus.state_dbg), 64'd0);
    check("cancel hi", 64'(bus.hi_out), 64'h64);
    check("cancel lo", 64'(bus.lo_out), 64'hFFFFFFFF);
    check("cancel div_zero", 64'(bus.div_zero), 64'd1);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("cancel no_done", 64'(done_seen), 64'd0);

    run_op("multu_clear_dz", OP_MULTU, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0);
    run_op("divu_plain", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);

    // start with new operands during CALC must be ignored
    start_op(OP_MULTU, 32'd5, 32'd5);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    check("ignored_start latency", 64'(n), 64'd28);
    check("ignored_start lo", 64'(bus.lo_out), 64'd25);
    check("ignored_start hi", 64'(bus.hi_out), 64'd0);
    tick();
    tick();
    check("ignored_start no_relaunch", 64'(bus.busy), 64'd0);

    // cancel together with start in IDLE: nothing launches
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = OP_MULTU;
    bus.a      = 32'd8;
    bus.b      = 32'd8;
    tick();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel busy", 64'(bus.busy), 64'd0);
    check("start_cancel state", 64'(bus.state_dbg), 64'd0);

    // reset during CALC
    start_op(OP_MULTU, 32'd7, 32'd7);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst div_zero", 64'(bus.div_zero), 64'd0);
    check("midrst hi", 64'(bus.hi_out), 64'd0);
    check("midrst lo", 64'(bus.lo_out), 64'd0);
    check("midrst state", 64'(bus.state_dbg), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("midrst no_done", 64'(done_seen), 64'd0);

    run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
